// File: rtl/pc_seq_ctrl.sv
// PC sequencing controller: turns branch, jump, load-use and memory-busy events into
// PC-select, stall and pipeline-flush controls, and keeps saturating performance counters.
module pc_seq_ctrl #(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             ReSet_n,
    input  logic             branch_req,
    input  logic             jump_req,
    input  logic             load_use,
    input  logic             mem_busy,
    output logic             PcSel,
    output logic             dojump,
    output logic             do_stall,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2,
        StFlush   = 2'd3
    } state_e;

    localparam logic [2:0] BubbleLoad = 3'(LU_STALL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       bub_q, bub_d;
    logic             pend_br_q, pend_br_d;
    logic             pend_j_q, pend_j_d;
    logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

    logic pc_sel_c, dojump_c, stall_c, flush_ifid_c, flush_idex_c;
    logic br_eff, j_eff, lu_eff, run_like, take_br;

    // Next-state and same-cycle control decode; mem_busy overrides everything.
    always_comb begin
        pc_sel_c     = 1'b0;
        dojump_c     = 1'b0;
        stall_c      = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        state_d      = state_q;
        bub_d        = bub_q;
        pend_br_d    = pend_br_q;
        pend_j_d     = pend_j_q;
        br_eff       = branch_req;
        j_eff        = jump_req;
        lu_eff       = load_use;
        run_like     = 1'b0;
        take_br      = 1'b0;

        if (mem_busy) begin
            stall_c = 1'b1;
            state_d = StMemWait;
            bub_d   = '0;
            // Remember redirects seen while frozen; a branch supersedes a jump.
            if (state_q == StMemWait) begin
                pend_br_d = pend_br_q | branch_req;
                pend_j_d  = (pend_j_q | jump_req) & ~pend_br_d;
            end
        end else begin
            case (state_q)
                StRun: run_like = 1'b1;
                StMemWait: begin
                    run_like  = 1'b1;
                    br_eff    = branch_req | pend_br_q;
                    j_eff     = jump_req | pend_j_q;
                    pend_br_d = 1'b0;
                    pend_j_d  = 1'b0;
                end
                StLuStall: begin
                    if (branch_req) begin
                        take_br = 1'b1;
                    end else begin
                        stall_c      = 1'b1;
                        flush_idex_c = 1'b1;
                        bub_d        = bub_q - 3'd1;
                        state_d      = (bub_q == 3'd1) ? StRun : StLuStall;
                    end
                end
                StFlush: begin
                    if (branch_req) take_br = 1'b1;
                    else            state_d = StRun;
                end
                default: state_d = StRun;
            endcase

            if (run_like) begin
                if (br_eff) begin
                    take_br = 1'b1;
                end else if (j_eff) begin
                    dojump_c     = 1'b1;
                    flush_ifid_c = 1'b1;
                    state_d      = StRun;
                end else if (lu_eff) begin
                    stall_c      = 1'b1;
                    flush_idex_c = 1'b1;
                    bub_d        = BubbleLoad;
                    state_d      = (LU_STALL_CYCLES > 1) ? StLuStall : StRun;
                end else begin
                    state_d = StRun;
                end
            end

            // A taken branch squashes the wrong path, including any pending bubbles.
            if (take_br) begin
                pc_sel_c     = 1'b1;
                flush_ifid_c = 1'b1;
                flush_idex_c = 1'b1;
                bub_d        = '0;
                state_d      = StFlush;
            end
        end
    end

    // Sequencer state, bubble counter and pending-redirect flags.
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            state_q   <= StRun;
            bub_q     <= '0;
            pend_br_q <= 1'b0;
            pend_j_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bub_q     <= bub_d;
            pend_br_q <= pend_br_d;
            pend_j_q  <= pend_j_d;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if ((pc_sel_c || dojump_c) && (redirect_cnt_q != '1)) begin
                redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs are combinational, so reset must also mask them directly.
    assign PcSel        = pc_sel_c & ReSet_n;
    assign dojump       = dojump_c & ReSet_n;
    assign do_stall     = stall_c & ReSet_n;
    assign flush_ifid   = flush_ifid_c & ReSet_n;
    assign flush_idex   = flush_idex_c & ReSet_n;
    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, number of bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have port Clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port ReSet_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port branch_req  in  1  taken branch resolved in EX; target already presented to the PC unit.
REQ-006 SHALL have port jump_req  in  1  jump decoded in ID.
REQ-007 SHALL have port load_use  in  1  load-use hazard detected in ID.
REQ-008 SHALL have port mem_busy  in  1  multi-cycle data memory busy; the whole pipeline freezes.
REQ-009 SHALL have port PcSel  out  1  select branch target.
REQ-010 SHALL have port dojump  out  1  select jump target.
REQ-011 SHALL have port do_stall  out  1  hold PC.
REQ-012 SHALL have port flush_ifid  out  1  squash the IF/ID register.
REQ-013 SHALL have port flush_idex  out  1  squash the ID/EX register (insert bubble).
REQ-014 SHALL have port redirect_cnt  out  CNT_W  number of redirects issued.
REQ-015 SHALL have port stall_cnt  out  CNT_W  number of cycles with do_stall=1.

Function
REQ-016 SHALL use states RUN, LU_STALL, MEM_WAIT and FLUSH, held in a registered state; outputs are combinational from state and inputs, valid in the same cycle.
REQ-017 SHALL never assert PcSel and dojump together, and SHALL force do_stall=0 in any cycle where either is asserted.
REQ-018 SHALL give mem_busy the highest priority in every state: do_stall=1, PcSel=dojump=0, no flush, next state MEM_WAIT.
REQ-019 In RUN with branch_req=1, SHALL drive PcSel=1, flush_ifid=1 and flush_idex=1, move to FLUSH, and drop any simultaneous jump_req or load_use (wrong path).
REQ-020 In RUN with jump_req=1 and branch_req=0, SHALL drive dojump=1 and flush_ifid=1, stay in RUN, and drop any simultaneous load_use.
REQ-021 In RUN with load_use=1 only, SHALL drive do_stall=1 and flush_idex=1, load the bubble counter with LU_STALL_CYCLES-1, and move to LU_STALL, or stay in RUN when LU_STALL_CYCLES=1.
REQ-022 In LU_STALL, SHALL drive do_stall=1 and flush_idex=1 and ignore load_use; branch_req preempts as in REQ-019; otherwise decrement the counter and return to RUN when it reaches 0.
REQ-023 In FLUSH (one cycle), SHALL ignore jump_req and load_use, honour branch_req as in REQ-019 (re-entering FLUSH), and otherwise drive all outputs 0 and return to RUN.
REQ-024 In MEM_WAIT, SHALL capture branch_req and jump_req into sticky pend_br and pend_j, with branch overriding jump (pend_j is cleared when pend_br is set).
REQ-025 On the first cycle of MEM_WAIT with mem_busy=0, SHALL act as RUN with inputs OR-ed with the pending bits, clear pend_br and pend_j, and take the resulting transition.
REQ-026 SHALL increment redirect_cnt on every cycle where PcSel or dojump is 1, and increment stall_cnt on every cycle where do_stall=1.
REQ-027 SHALL saturate both counters at all-ones with no wrap.

Reset
REQ-028 While ReSet_n=0, SHALL immediately (asynchronously) force state RUN, all outputs 0, both counters 0, the bubble counter 0, and pend_br=pend_j=0.
REQ-029 Reset asserted mid-LU_STALL, MEM_WAIT or FLUSH SHALL discard all pending work; the first posedge after release behaves as RUN.

Verification
REQ-030 Scenario: branch_req=1 and jump_req=1 in the same RUN cycle -> PcSel=1, dojump=0, both flushes=1; next cycle in FLUSH with jump_req=1 -> all outputs 0; redirect_cnt=1.
REQ-031 Scenario: LU_STALL_CYCLES=3 and a load_use pulse -> do_stall=1 and flush_idex=1 for exactly 3 cycles; stall_cnt=3; load_use held high during LU_STALL causes no extension.
REQ-032 Scenario: mem_busy high for 4 cycles with a jump_req pulse in cycle 2 and a branch_req pulse in cycle 3 -> do_stall=1 for 4 cycles; first cycle after release PcSel=1, dojump=0; pending cleared.
REQ-033 Scenario: branch_req during LU_STALL (2 cycles remaining) -> PcSel=1, do_stall=0 that cycle; FLUSH next; bubbles abandoned.
REQ-034 Scenario: ReSet_n pulsed low mid-MEM_WAIT with pend_br=1 -> outputs 0 within the same cycle; after release, no branch redirect is issued and counters read 0.
REQ-035 Scenario: counters preloaded near the limit (CNT_W=4) with 20 stall cycles -> stall_cnt holds at 15.
